// File: rtl/axi_wburst_master.sv
// axi_wburst_master: issues one AXI4 INCR write burst per request, streaming beats straight from the DMA producer
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
module axi_wburst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_w_valid,
  input  logic [ADDR_W-1:0]     dma_w_addr,
  input  logic [DATA_W-1:0]     dma_w_wdata,
  input  logic [DATA_W/8-1:0]   dma_w_wstrb,
  input  logic [`AXI_LEN_W-1:0] dma_w_len,
  output logic                  dma_w_ready,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [`AXI_LEN_W-1:0] m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  clear
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
  localparam logic [2:0] SIZE = 3'($clog2(DATA_W/8));
  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [`AXI_LEN_W-1:0] len_q, len_d, cnt_q, cnt_d;
  logic                  error_q, error_d;
  logic                  w_hs;
  // state and burst-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      awaddr_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      awaddr_q <= awaddr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
    end
  end
  // next state: request -> address phase -> data beats -> write response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = dma_w_valid ? ADDR : IDLE;
      ADDR:    state_d = m_axi_awready ? DATA : ADDR;
      DATA:    state_d = (w_hs && m_axi_wlast) ? RESP : DATA;
      RESP:    state_d = m_axi_bvalid ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // burst context capture, beat counter and sticky error (a new error beats clear)
  always_comb begin
    awaddr_d = (state_q == IDLE && dma_w_valid) ? dma_w_addr : awaddr_q;
    len_d    = (state_q == IDLE && dma_w_valid) ? dma_w_len : len_q;
    cnt_d    = (state_q == ADDR && m_axi_awready) ? '0 : w_hs ? cnt_q + `AXI_LEN_W'(1) : cnt_q;
    error_d  = (state_q == RESP && m_axi_bvalid && (m_axi_bresp inside {2'b10, 2'b11})) || (error_q && !clear);
  end
  // handshake and status outputs decoded from the current state
  always_comb begin
    busy          = state_q != IDLE;
    m_axi_awvalid = state_q == ADDR;
    m_axi_wvalid  = state_q == DATA && dma_w_valid;
    dma_w_ready   = state_q == DATA && m_axi_wready;
    m_axi_wlast   = state_q == DATA && cnt_q == len_q;
    m_axi_bready  = state_q == RESP;
    done          = state_q == RESP && m_axi_bvalid;
    w_hs          = m_axi_wvalid && m_axi_wready;
  end
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = SIZE;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wdata   = dma_w_wdata;
  assign m_axi_wstrb   = dma_w_wstrb;
  assign error         = error_q;
endmodule

// File: doc/axi_wburst_master.md
AXI_WBURST_MASTER -- requirements
Module: axi_wburst_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits (32, 64 or 128).
REQ-003 SHALL use `AXI_LEN_W (8) from axi_dma.vh for all burst-length fields.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  system clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have the ports: dma_w_valid  in  1  beat/request valid; dma_w_addr  in  ADDR_W  burst start address, DATA_W-aligned; dma_w_wdata  in  DATA_W  beat data; dma_w_wstrb  in  DATA_W/8  beat byte strobes; dma_w_len  in  `AXI_LEN_W  beats minus one; dma_w_ready  out  1  beat accepted.
REQ-006 SHALL have the AXI write-address ports: m_axi_awaddr  out  ADDR_W; m_axi_awlen  out  `AXI_LEN_W; m_axi_awsize  out  3; m_axi_awburst  out  2; m_axi_awvalid  out  1; m_axi_awready  in  1.
REQ-007 SHALL have the AXI write-data ports: m_axi_wdata  out  DATA_W; m_axi_wstrb  out  DATA_W/8; m_axi_wlast  out  1; m_axi_wvalid  out  1; m_axi_wready  in  1.
REQ-008 SHALL have the AXI write-response ports: m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1.
REQ-009 SHALL have the status ports: busy  out  1  burst in progress; done  out  1  one-cycle pulse at burst end; error  out  1  sticky, set when a response is SLVERR or DECERR.
REQ-010 SHALL have the control port: clear  in  1  clears error.

Function
REQ-011 SHALL implement FSM states IDLE, ADDR, DATA and RESP.
REQ-012 In IDLE with dma_w_valid=1, SHALL latch dma_w_addr into awaddr_r and dma_w_len into len_r, and go to ADDR next cycle; dma_w_ready=0 in IDLE (the beat is not consumed).
REQ-013 In ADDR, SHALL drive m_axi_awvalid=1 with awaddr_r and len_r held stable until the cycle m_axi_awready=1, then go to DATA.
REQ-014 SHALL tie m_axi_awsize to log2(DATA_W/8) and m_axi_awburst to 2'b01 (INCR) in all states.
REQ-015 In DATA, SHALL drive m_axi_wvalid=dma_w_valid and dma_w_ready=m_axi_wready, with wdata and wstrb combinationally passed through (zero latency, no buffering).
REQ-016 SHALL count beats with an `AXI_LEN_W-bit counter cleared on ADDR exit and incremented on each wvalid&&wready.
REQ-017 SHALL assert m_axi_wlast=1 iff in DATA and counter==len_r.
REQ-018 On the wlast handshake, SHALL go to RESP.
REQ-019 In RESP, SHALL assert m_axi_bready=1; on m_axi_bvalid=1, SHALL go to IDLE, pulse done for exactly one cycle, and set error if m_axi_bresp[1]=1.
REQ-020 SHALL hold busy=1 in every state except IDLE.
REQ-021 Outside DATA, SHALL hold m_axi_wvalid=0 and m_axi_wlast=0 regardless of dma_w_valid.
REQ-022 Outside RESP, SHALL hold m_axi_bready=0.
REQ-023 When dma_w_valid drops mid-burst, SHALL deassert wvalid, keep the counter unchanged and stay in DATA.
REQ-024 With len_r=0 (single beat), SHALL assert wlast on the first DATA beat.
REQ-025 With len_r=255, SHALL issue exactly 256 beats; the counter SHALL NOT wrap before wlast.
REQ-026 With awready asserted already in the ADDR entry cycle, SHALL complete the AW handshake in that cycle; the first W beat may complete in the following cycle at the earliest.
REQ-027 When clear and an error response occur in the same cycle, setting error SHALL take priority over clear.
REQ-028 Back-to-back bursts: SHALL allow a new dma_w_valid to be sampled in IDLE on the cycle after done.
REQ-029 SHALL NOT issue bursts that cross a 4 KB boundary; this is the producer's responsibility and is not checked.

Reset
REQ-030 While rst=1 at clk, SHALL enter IDLE and set busy=0, done=0, error=0, m_axi_awvalid=0, m_axi_wvalid=0, m_axi_wlast=0, m_axi_bready=0, dma_w_ready=0, counter=0.
REQ-031 Reset mid-burst SHALL abandon the burst with no further AXI handshakes; the AXI slave is reset together with this block.

Verification
REQ-032 Single beat: addr=0x100, len=0, wdata=0xDEADBEEF, wstrb=0xF, awready=wready=bvalid=1 -> one AW with awlen=0 and awsize=2, one W with wlast=1, done pulses once, error=0.
REQ-033 Burst of 4 with wready toggling 1,0,1,0... -> exactly 4 beats, wlast only on the 4th, dma_w_ready mirrors wready, data order preserved.
REQ-034 Producer stall: dma_w_valid=0 for 3 cycles after beat 2 of len=3 -> wvalid=0 during the stall, counter holds, wlast on beat 4.
REQ-035 Error: bresp=2'b10 -> error=1 after done; clear=1 -> error=0; error response and clear in the same cycle -> error=1.
REQ-036 Max burst: len=255, awready delayed 5 cycles -> awvalid held stable for 6 cycles, 256 beats, wlast on the 256th beat only.
REQ-037 Reset at beat 3 of len=7 -> next cycle all outputs at reset values; a fresh burst afterwards completes normally.
